// File: rtl/memory_unit.sv
// MAR plus DEPTH x DW RAM for the 8-bit CPU: run mode follows lm/ce/we,
// program mode streams bytes in over a valid/ready handshake.
module memory_unit #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] bus_in,
    output logic [DW-1:0] bus_out,
    output logic          bus_oe,
    input  logic          lm,
    input  logic          ce,
    input  logic          we,
    input  logic          prog_mode,
    input  logic          prog_valid,
    input  logic [DW-1:0] prog_data,
    output logic          prog_ready,
    output logic          prog_done,
    output logic [AW-1:0] mar_out
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PROG,
        ST_FULL
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] mar_q, mar_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [DW-1:0] mem_q [DEPTH];

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        ptr_d   = ptr_q;
        wr_en   = 1'b0;
        wr_addr = mar_q;
        wr_data = bus_in;
        case (state_q)
            ST_RUN: begin
                // A write uses the pre-edge MAR even when lm reloads it on the same edge
                if (lm) mar_d = bus_in[AW-1:0];
                if (we) wr_en = 1'b1;
                if (prog_mode) begin
                    state_d = ST_PROG;
                    ptr_d   = '0;
                end
            end
            ST_PROG: begin
                if (prog_valid) begin
                    wr_en   = 1'b1;
                    wr_addr = ptr_q;
                    wr_data = prog_data;
                    ptr_d   = ptr_q + AW'(1);
                    if (ptr_q == AW'(DEPTH - 1)) state_d = ST_FULL;
                end
                if (!prog_mode) begin
                    state_d = ST_RUN;
                    ptr_d   = '0;
                    mar_d   = '0;
                end
            end
            ST_FULL: begin
                if (!prog_mode) begin
                    state_d = ST_RUN;
                    ptr_d   = '0;
                    mar_d   = '0;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            mar_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            ptr_q   <= ptr_d;
        end
    end

    // Memory is built from resettable flops so reset can clear every word at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign bus_oe     = (state_q == ST_RUN) && ce;
    assign bus_out    = bus_oe ? mem_q[mar_q] : '0;
    assign prog_ready = (state_q == ST_PROG);
    assign prog_done  = (state_q == ST_FULL);
    assign mar_out    = mar_q;

endmodule

// File: tb/tb_memory_unit.sv
// Self-checking bench for memory_unit: random run/program traffic checked
// against an array model of the RAM and MAR.
module tb_memory_unit;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] bus_in;
    logic [DW-1:0] bus_out;
    logic          bus_oe;
    logic          lm;
    logic          ce;
    logic          we;
    logic          prog_mode;
    logic          prog_valid;
    logic [DW-1:0] prog_data;
    logic          prog_ready;
    logic          prog_done;
    logic [AW-1:0] mar_out;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] model_mem [DEPTH];
    logic [AW-1:0] model_mar;

    always #5 clk = ~clk;

    memory_unit #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_in    (bus_in),
        .bus_out   (bus_out),
        .bus_oe    (bus_oe),
        .lm        (lm),
        .ce        (ce),
        .we        (we),
        .prog_mode (prog_mode),
        .prog_valid(prog_valid),
        .prog_data (prog_data),
        .prog_ready(prog_ready),
        .prog_done (prog_done),
        .mar_out   (mar_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_mar = '0;
    endtask

    task automatic load_mar(input logic [DW-1:0] b);
        bus_in = b;
        lm = 1'b1;
        step();
        lm = 1'b0;
        model_mar = b[AW-1:0];
    endtask

    task automatic write_byte(input logic [DW-1:0] b);
        bus_in = b;
        we = 1'b1;
        step();
        we = 1'b0;
        model_mem[model_mar] = b;
    endtask

    task automatic read_addr(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic oe);
        load_mar({4'($urandom), a});
        ce = 1'b1;
        #1;
        d  = bus_out;
        oe = bus_oe;
        ce = 1'b0;
        #1;
    endtask

    task automatic enter_prog();
        prog_mode = 1'b1;
        step();
    endtask

    task automatic exit_prog();
        prog_valid = 1'b0;
        prog_mode  = 1'b0;
        step();
        model_mar = '0;
    endtask

    task automatic test_reset();
        logic [DW-1:0] d;
        logic oe;
        for (int i = 0; i < 4; i++) begin
            load_mar(8'($urandom));
            write_byte(8'($urandom));
        end
        bus_in = 8'h3A;
        lm = 1'b1;
        #2;
        rst = 1'b1;
        lm = 1'b0;
        #1;
        step();
        rst = 1'b0;
        step();
        model_clear();
        checks++;
        if (mar_out !== 4'h0) begin
            errors++;
            $display("[TB] FAIL reset_mar: got %0h expected 0", mar_out);
        end
        checks++;
        if (bus_oe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_bus_oe: got %0b expected 0", bus_oe);
        end
        checks++;
        if (prog_ready !== 1'b0 || prog_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_prog: got ready=%0b done=%0b expected 0/0", prog_ready, prog_done);
        end
        read_addr(4'd5, d, oe);
        checks++;
        if (d !== 8'h00 || oe !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_mem5: got %0h oe=%0b expected 00 oe=1", d, oe);
        end
    endtask

    task automatic test_run_rw();
        logic [DW-1:0] d, old_v, new_v;
        logic oe;
        logic [AW-1:0] a;
        load_mar(8'h3A);
        checks++;
        if (mar_out !== 4'hA) begin
            errors++;
            $display("[TB] FAIL run_lm: got %0h expected a", mar_out);
        end
        write_byte(8'h5C);
        ce = 1'b1;
        #1;
        checks++;
        if (bus_out !== 8'h5C || bus_oe !== 1'b1) begin
            errors++;
            $display("[TB] FAIL run_read: got %0h oe=%0b expected 5c oe=1", bus_out, bus_oe);
        end
        ce = 1'b0;
        #1;
        checks++;
        if (bus_out !== 8'h00 || bus_oe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL run_idle: got %0h oe=%0b expected 00 oe=0", bus_out, bus_oe);
        end
        for (int i = 0; i < 24; i++) begin
            load_mar(8'($urandom));
            write_byte(8'($urandom));
        end
        for (int i = 0; i < DEPTH; i++) begin
            read_addr(AW'(i), d, oe);
            checks++;
            if (d !== model_mem[i] || oe !== 1'b1) begin
                errors++;
                $display("[TB] FAIL run_rand_read[%0d]: got %0h expected %0h", i, d, model_mem[i]);
            end
        end
        a = AW'($urandom);
        load_mar({4'h0, a});
        old_v = model_mem[a];
        new_v = ~old_v;
        bus_in = new_v;
        we = 1'b1;
        ce = 1'b1;
        #1;
        checks++;
        if (bus_out !== old_v) begin
            errors++;
            $display("[TB] FAIL ce_we_old: got %0h expected %0h", bus_out, old_v);
        end
        step();
        we = 1'b0;
        model_mem[a] = new_v;
        checks++;
        if (bus_out !== new_v) begin
            errors++;
            $display("[TB] FAIL ce_we_new: got %0h expected %0h", bus_out, new_v);
        end
        ce = 1'b0;
    endtask

    task automatic test_lm_we();
        logic [DW-1:0] d;
        logic oe;
        load_mar(8'h02);
        bus_in = 8'h07;
        lm = 1'b1;
        we = 1'b1;
        step();
        lm = 1'b0;
        we = 1'b0;
        model_mem[2] = 8'h07;
        model_mar = 4'h7;
        checks++;
        if (mar_out !== 4'h7) begin
            errors++;
            $display("[TB] FAIL lm_we_mar: got %0h expected 7", mar_out);
        end
        read_addr(4'd2, d, oe);
        checks++;
        if (d !== 8'h07) begin
            errors++;
            $display("[TB] FAIL lm_we_mem2: got %0h expected 07", d);
        end
    endtask

    task automatic test_full_load();
        logic [DW-1:0] d, b;
        logic oe;
        int accepts;
        enter_prog();
        checks++;
        if (prog_ready !== 1'b1 || prog_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_enter: got ready=%0b done=%0b expected 1/0", prog_ready, prog_done);
        end
        accepts = 0;
        prog_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            b = (accepts < DEPTH) ? 8'(8'h10 + accepts) : 8'hFF;
            prog_data = b;
            if (prog_ready === 1'b1) begin
                model_mem[accepts % DEPTH] = b;
                accepts++;
            end
            step();
        end
        checks++;
        if (accepts != DEPTH) begin
            errors++;
            $display("[TB] FAIL full_accepts: got %0d expected %0d", accepts, DEPTH);
        end
        checks++;
        if (prog_ready !== 1'b0 || prog_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_done: got ready=%0b done=%0b expected 0/1", prog_ready, prog_done);
        end
        exit_prog();
        checks++;
        if (mar_out !== 4'h0 || prog_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_exit: got mar=%0h done=%0b expected 0/0", mar_out, prog_done);
        end
        for (int i = 0; i < DEPTH; i++) begin
            read_addr(AW'(i), d, oe);
            checks++;
            if (d !== 8'(8'h10 + i)) begin
                errors++;
                $display("[TB] FAIL full_mem[%0d]: got %0h expected %0h", i, d, 8'(8'h10 + i));
            end
        end
    endtask

    task automatic test_partial_reentry();
        logic [DW-1:0] d;
        logic oe;
        int len;
        enter_prog();
        prog_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            prog_data = 8'(8'hA1 + k);
            model_mem[k] = prog_data;
            step();
        end
        exit_prog();
        checks++;
        if (mar_out !== 4'h0) begin
            errors++;
            $display("[TB] FAIL partial_exit1_mar: got %0h expected 0", mar_out);
        end
        enter_prog();
        prog_valid = 1'b1;
        prog_data = 8'hB1;
        model_mem[0] = 8'hB1;
        step();
        exit_prog();
        checks++;
        if (mar_out !== 4'h0) begin
            errors++;
            $display("[TB] FAIL partial_exit2_mar: got %0h expected 0", mar_out);
        end
        read_addr(4'd0, d, oe);
        checks++;
        if (d !== 8'hB1) begin
            errors++;
            $display("[TB] FAIL partial_mem0: got %0h expected b1", d);
        end
        read_addr(4'd1, d, oe);
        checks++;
        if (d !== 8'hA2) begin
            errors++;
            $display("[TB] FAIL partial_mem1: got %0h expected a2", d);
        end
        read_addr(4'd2, d, oe);
        checks++;
        if (d !== 8'hA3) begin
            errors++;
            $display("[TB] FAIL partial_mem2: got %0h expected a3", d);
        end
        len = int'($urandom_range(1, DEPTH - 1));
        enter_prog();
        prog_valid = 1'b1;
        for (int k = 0; k < len; k++) begin
            prog_data = 8'($urandom);
            model_mem[k] = prog_data;
            step();
        end
        exit_prog();
        for (int i = 0; i < DEPTH; i++) begin
            read_addr(AW'(i), d, oe);
            checks++;
            if (d !== model_mem[i]) begin
                errors++;
                $display("[TB] FAIL partial_rand[%0d] len=%0d: got %0h expected %0h", i, len, d, model_mem[i]);
            end
        end
    endtask

    task automatic test_isolation();
        logic [DW-1:0] d;
        logic oe;
        load_mar(8'h09);
        enter_prog();
        bus_in = 8'h99;
        ce = 1'b1;
        we = 1'b1;
        lm = 1'b1;
        #1;
        checks++;
        if (bus_oe !== 1'b0 || bus_out !== 8'h00) begin
            errors++;
            $display("[TB] FAIL iso_bus: got oe=%0b out=%0h expected 0/00", bus_oe, bus_out);
        end
        step();
        ce = 1'b0;
        we = 1'b0;
        lm = 1'b0;
        checks++;
        if (mar_out !== 4'h9) begin
            errors++;
            $display("[TB] FAIL iso_mar: got %0h expected 9", mar_out);
        end
        exit_prog();
        for (int i = 0; i < DEPTH; i++) begin
            read_addr(AW'(i), d, oe);
            checks++;
            if (d !== model_mem[i]) begin
                errors++;
                $display("[TB] FAIL iso_mem[%0d]: got %0h expected %0h", i, d, model_mem[i]);
            end
        end
    endtask

    task automatic test_reset_mid_prog();
        logic [DW-1:0] d;
        logic oe;
        enter_prog();
        prog_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            prog_data = 8'($urandom);
            step();
        end
        rst = 1'b1;
        #1;
        checks++;
        if (prog_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_async_ready: got %0b expected 0", prog_ready);
        end
        prog_valid = 1'b0;
        prog_mode = 1'b0;
        step();
        rst = 1'b0;
        step();
        model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            read_addr(AW'(i), d, oe);
            checks++;
            if (d !== 8'h00) begin
                errors++;
                $display("[TB] FAIL rst_mem[%0d]: got %0h expected 00", i, d);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus_in = '0;
        lm = 1'b0;
        ce = 1'b0;
        we = 1'b0;
        prog_mode = 1'b0;
        prog_valid = 1'b0;
        prog_data = '0;
        model_clear();
        step();
        step();
        rst = 1'b0;
        step();
        $display("[TB] starting memory_unit tests");
        test_reset();
        test_run_rw();
        test_lm_we();
        test_full_load();
        test_partial_reentry();
        test_isolation();
        test_reset_mid_prog();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
